// File: rtl/ttc_intr_pkg.sv
// Shared types and constants for the TTC interrupt scheduler.
package ttc_intr_pkg;

  localparam int INTR_W  = 6;
  localparam int MAX_CNT = 8;
  localparam int SEL_W   = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GRANT    = 3'd1,
    WAIT_ACK = 3'd2,
    CLEAR    = 3'd3,
    CHECK    = 3'd4
  } state_e;

endpackage

// File: rtl/ttc_rr_arbiter.sv
// Rotating-priority arbiter: the first requester at or after ptr wins.
module ttc_rr_arbiter
  import ttc_intr_pkg::*;
#(
  parameter int NUM_CNT = 3
) (
  input  logic [NUM_CNT-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [NUM_CNT-1:0] gnt,
  output logic [SEL_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  logic [2*NUM_CNT-1:0] req_dbl_s;
  logic [NUM_CNT-1:0]   req_rot_s;
  logic [SEL_W-1:0]     off_s;
  logic [SEL_W:0]       sum_s;

  // Rotating the doubled request vector puts the ptr position at bit 0.
  assign req_dbl_s = {req, req};
  assign req_rot_s = NUM_CNT'(req_dbl_s >> ptr);
  assign gnt_any   = |req;

  // Lowest set bit of the rotated vector, mapped back to an absolute index.
  always_comb begin
    off_s = '0;
    for (int j = NUM_CNT - 1; j >= 0; j--) begin
      if (req_rot_s[j]) begin
        off_s = SEL_W'(j);
      end else begin
        off_s = off_s;
      end
    end
    sum_s = {1'b0, ptr} + {1'b0, off_s};
    if (sum_s >= (SEL_W + 1)'(NUM_CNT)) begin
      gnt_idx = SEL_W'(sum_s - (SEL_W + 1)'(NUM_CNT));
    end else begin
      gnt_idx = sum_s[SEL_W-1:0];
    end
    for (int j = 0; j < NUM_CNT; j++) begin
      gnt[j] = gnt_any & (gnt_idx == SEL_W'(j));
    end
  end

endmodule

// File: rtl/ttc_intr_sched.sv
// TTC interrupt scheduler: arbitrate, present vector, await ack, clear and verify.
// Define TTC_INTR_SCHED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module ttc_intr_sched
  import ttc_intr_pkg::*;
#(
  parameter int NUM_CNT     = 3,
  parameter int INTR_W      = ttc_intr_pkg::INTR_W,
  parameter int ACK_TIMEOUT = 255,
  parameter int CLR_RETRY   = 3
) (
  input  logic                      pclk,
  input  logic                      p_reset,
  input  logic [NUM_CNT*INTR_W-1:0] irq_vec,
  input  logic [NUM_CNT-1:0]        svc_en,
  input  logic                      irq_ack,
  input  logic                      err_clr,
  output logic [NUM_CNT-1:0]        clear_interrupt,
  output logic                      irq,
  output logic                      irq_valid,
  output logic [SEL_W-1:0]          sel_id,
  output logic [INTR_W-1:0]         sel_vec,
  output logic                      timeout_err,
  output logic                      clr_fail
);

  state_e             state_r;
  logic [NUM_CNT-1:0] gnt_oh_r;
  logic [SEL_W-1:0]   gnt_idx_r;
  logic [SEL_W-1:0]   sel_id_r;
  logic [SEL_W-1:0]   rr_ptr_r;
  logic [INTR_W-1:0]  sel_vec_r;
  logic               irq_valid_r;
  logic               timeout_err_r;
  logic               clr_fail_r;
  logic [NUM_CNT-1:0] clr_r;
  logic [7:0]         tmo_r;
  logic [3:0]         retry_r;
  logic               chk_cnt_r;

  logic [INTR_W-1:0]  vec_s [NUM_CNT];
  logic [NUM_CNT-1:0] req_s;
  logic [NUM_CNT-1:0] arb_gnt_s;
  logic [SEL_W-1:0]   arb_idx_s;
  logic               arb_any_s;
  logic [INTR_W-1:0]  gnt_vec_s;
  logic [INTR_W-1:0]  sel_cur_s;
  logic [NUM_CNT-1:0] clr_oh_s;
  logic [SEL_W-1:0]   rr_next_s;
  logic [7:0]         tmo_inc_s;

  for (genvar j = 0; j < NUM_CNT; j++) begin : g_req
    assign vec_s[j] = irq_vec[j*INTR_W +: INTR_W];
    assign req_s[j] = (|vec_s[j]) & svc_en[j];
  end

  ttc_rr_arbiter #(.NUM_CNT(NUM_CNT)) u_arb (
    .req     (req_s),
    .ptr     (rr_ptr_r),
    .gnt     (arb_gnt_s),
    .gnt_idx (arb_idx_s),
    .gnt_any (arb_any_s)
  );

  // Vector muxes for the granted and the in-service counter, plus clear one-hot.
  always_comb begin
    gnt_vec_s = '0;
    sel_cur_s = '0;
    for (int j = 0; j < NUM_CNT; j++) begin
      if (gnt_oh_r[j]) begin
        gnt_vec_s = gnt_vec_s | vec_s[j];
      end else begin
        gnt_vec_s = gnt_vec_s;
      end
      if (sel_id_r == SEL_W'(j)) begin
        sel_cur_s = vec_s[j];
      end else begin
        sel_cur_s = sel_cur_s;
      end
      clr_oh_s[j] = (sel_id_r == SEL_W'(j));
    end
    if (sel_id_r == SEL_W'(NUM_CNT - 1)) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = sel_id_r + SEL_W'(1);
    end
    tmo_inc_s = tmo_r + 8'd1;
  end

  // Service state machine with all outputs registered.
  always_ff @(posedge pclk or posedge p_reset) begin
    if (p_reset) begin
      state_r       <= IDLE;
      gnt_oh_r      <= '0;
      gnt_idx_r     <= '0;
      sel_id_r      <= '0;
      rr_ptr_r      <= '0;
      sel_vec_r     <= '0;
      irq_valid_r   <= 1'b0;
      timeout_err_r <= 1'b0;
      clr_fail_r    <= 1'b0;
      clr_r         <= '0;
      tmo_r         <= 8'd0;
      retry_r       <= 4'd0;
      chk_cnt_r     <= 1'b0;
    end else begin
      clr_r <= '0;
      if (err_clr) begin
        timeout_err_r <= 1'b0;
        clr_fail_r    <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (arb_any_s) begin
            gnt_oh_r  <= arb_gnt_s;
            gnt_idx_r <= arb_idx_s;
            state_r   <= GRANT;
          end
        end
        GRANT: begin
          sel_id_r    <= gnt_idx_r;
          sel_vec_r   <= gnt_vec_s;
          irq_valid_r <= 1'b1;
          tmo_r       <= 8'd0;
          state_r     <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (irq_ack || (tmo_inc_s == 8'(ACK_TIMEOUT))) begin
            if (!irq_ack) begin
              timeout_err_r <= 1'b1;
            end
            irq_valid_r <= 1'b0;
            clr_r       <= clr_oh_s;
            tmo_r       <= 8'd0;
            state_r     <= CLEAR;
          end else begin
            tmo_r <= tmo_inc_s;
          end
        end
        CLEAR: begin
          chk_cnt_r <= 1'b0;
          state_r   <= CHECK;
        end
        CHECK: begin
          // Counter register needs two cycles to reflect the clear.
          if (!chk_cnt_r) begin
            chk_cnt_r <= 1'b1;
          end else if (((sel_cur_s & sel_vec_r) != '0) && (retry_r < 4'(CLR_RETRY))) begin
            retry_r <= retry_r + 4'd1;
            clr_r   <= clr_oh_s;
            state_r <= CLEAR;
          end else begin
            if ((sel_cur_s & sel_vec_r) != '0) begin
              clr_fail_r <= 1'b1;
            end
`ifdef TTC_INTR_SCHED_PRIO_EN
            rr_ptr_r <= '0;
`else
            rr_ptr_r <= rr_next_s;
`endif
            retry_r <= 4'd0;
            tmo_r   <= 8'd0;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign clear_interrupt = clr_r;
  assign irq_valid       = irq_valid_r;
  assign irq             = irq_valid_r;
  assign sel_id          = sel_id_r;
  assign sel_vec         = sel_vec_r;
  assign timeout_err     = timeout_err_r;
  assign clr_fail        = clr_fail_r;

endmodule
